control_comparador: RTL and testbench
=====================================

CONTROL_COMPARADOR -- requirements
Module: control_comparador

Interface
REQ-001 Parameter: MAX_INTENTOS, default 7, number of attempts allowed per round (legal range 1..15).
REQ-002 Port: clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: inicio  input  1  start/restart a round; synchronous, level-sampled each cycle.
REQ-005 Port: valido  input  1  attempt strobe; operands at the 4-bit comparator are stable while high.
REQ-006 Port: E  input  1  comparator result, operand A equals B.
REQ-007 Port: G  input  1  comparator result, A greater than B.
REQ-008 Port: L  input  1  comparator result, A less than B.
REQ-009 Port: igual  output  1  registered copy of the last accepted E.
REQ-010 Port: mayor  output  1  registered copy of the last accepted G.
REQ-011 Port: menor  output  1  registered copy of the last accepted L.
REQ-012 Port: intentos  output  4  number of accepted attempts in the current round.
REQ-013 Port: jugando  output  1  high while in state JUGANDO.
REQ-014 Port: gano  output  1  high while in state GANO.
REQ-015 Port: perdio  output  1  high while in state PERDIO.
REQ-016 Port: error  output  1  one-cycle pulse when an attempt is rejected for an illegal E/G/L code.

Function
REQ-017 The FSM SHALL have four states: ESPERA, JUGANDO, GANO and PERDIO.
REQ-018 An attempt edge SHALL be the cycle in which valido=1 and the registered valido of the previous cycle was 0; a held valido SHALL produce exactly one attempt edge.
REQ-019 A legal code SHALL mean exactly one of E, G and L is high; any other combination is illegal.
REQ-020 In ESPERA, the block SHALL ignore attempt edges and SHALL move to JUGANDO on inicio=1.
REQ-021 In JUGANDO, an attempt edge with a legal code SHALL increment intentos and latch E/G/L into igual/mayor/menor; outputs SHALL be visible the cycle after the edge (1-cycle latency).
REQ-022 In JUGANDO, an accepted attempt with E=1 SHALL transition to GANO.
REQ-023 In JUGANDO, an accepted attempt with E=0 that makes intentos reach MAX_INTENTOS SHALL transition to PERDIO.
REQ-024 If a win occurs on the attempt that reaches MAX_INTENTOS, GANO SHALL take priority over PERDIO.
REQ-025 In JUGANDO, an attempt edge with an illegal code SHALL pulse error for one cycle.
REQ-026 An illegal-code attempt SHALL leave intentos, igual/mayor/menor and the state unchanged.
REQ-027 In GANO and PERDIO, the block SHALL ignore attempt edges, SHALL hold all outputs, and SHALL never assert error.
REQ-028 inicio=1 in any state SHALL, on the next edge, enter JUGANDO and clear intentos, igual, mayor and menor.
REQ-029 inicio=1 coincident with an attempt edge SHALL win; that attempt SHALL be discarded.
REQ-030 intentos SHALL never exceed MAX_INTENTOS and SHALL never wrap.
REQ-031 Exactly one of jugando, gano and perdio SHALL be high outside ESPERA; all three SHALL be low in ESPERA.

Reset
REQ-032 rst=1 SHALL immediately, without waiting for clk, force the following values: state ESPERA, intentos=0, igual=mayor=menor=0, error=0, registered valido=0.
REQ-033 A reset asserted mid-round SHALL abandon the round; after release the block SHALL stay in ESPERA until inicio.
REQ-034 If valido is already high when rst deasserts, the first cycle SHALL count as an attempt edge.

Verification
REQ-035 Win on third attempt: rst, inicio, three valido pulses with codes G, L, E -> intentos=3, igual=1, gano=1, error never pulses.
REQ-036 Loss: MAX_INTENTOS=7, inicio, seven pulses with code G -> intentos=7, perdio=1, mayor=1; an eighth pulse -> no change.
REQ-037 Held strobe plus illegal code: valido held high for 5 cycles with code L -> intentos=1 only; then a pulse with E=G=1 -> error high for exactly 1 cycle and intentos stays 1.
REQ-038 Last-attempt win and restart: pulse E on attempt 7 -> gano=1, perdio=0; then inicio coincident with a valido edge -> jugando=1, intentos=0.
REQ-039 Asynchronous reset: assert rst between clock edges during JUGANDO with intentos=4 -> all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/control_comparador.sv
// control_comparador: round controller for a number-guessing game driven by a 4-bit comparator.
// Latency: an accepted attempt is reflected on igual/mayor/menor/intentos/state one cycle after its valido edge.
// Backpressure: none; every valido rising edge is consumed immediately (accepted, rejected or ignored).
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   inicio              start/restart a round (level, sampled every cycle, overrides everything else)
//   valido              attempt strobe; only its rising edge counts as an attempt
//   E, G, L             comparator result for the attempt (exactly one must be high)
//   igual/mayor/menor   last accepted comparator result
//   intentos            accepted attempts in the current round (0..MAX_INTENTOS)
//   jugando/gano/perdio one-hot round status; all low while waiting for inicio
//   error               one-cycle pulse for an attempt rejected because of an illegal E/G/L code
module control_comparador #(
    parameter int MAX_INTENTOS = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inicio,
    input  logic       valido,
    input  logic       E,
    input  logic       G,
    input  logic       L,
    output logic       igual,
    output logic       mayor,
    output logic       menor,
    output logic [3:0] intentos,
    output logic       jugando,
    output logic       gano,
    output logic       perdio,
    output logic       error
);

    typedef enum logic [1:0] {
        ESPERA  = 2'd0,
        JUGANDO = 2'd1,
        GANO    = 2'd2,
        PERDIO  = 2'd3
    } estado_t;

    localparam logic [3:0] MAX_INT4 = 4'(MAX_INTENTOS);

    estado_t    estado_q;
    logic       valido_q;
    logic [3:0] intentos_q;
    logic       igual_q;
    logic       mayor_q;
    logic       menor_q;
    logic       error_q;

    logic       att_edge;
    logic       codigo_legal;
    logic [3:0] intentos_inc;

    // A held strobe yields a single attempt: only the 0->1 transition counts.
    assign att_edge     = valido & ~valido_q;
    // Legal code: exactly one of the three comparator flags is set.
    assign codigo_legal = (E & ~G & ~L) | (~E & G & ~L) | (~E & ~G & L);
    assign intentos_inc = intentos_q + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q   <= ESPERA;
            valido_q   <= 1'b0;
            intentos_q <= 4'd0;
            igual_q    <= 1'b0;
            mayor_q    <= 1'b0;
            menor_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            valido_q <= valido;
            error_q  <= 1'b0;
            if (inicio) begin
                // Restart wins over any coincident attempt, which is dropped.
                estado_q   <= JUGANDO;
                intentos_q <= 4'd0;
                igual_q    <= 1'b0;
                mayor_q    <= 1'b0;
                menor_q    <= 1'b0;
            end else begin
                case (estado_q)
                    JUGANDO: begin
                        if (att_edge) begin
                            if (codigo_legal) begin
                                intentos_q <= intentos_inc;
                                igual_q    <= E;
                                mayor_q    <= G;
                                menor_q    <= L;
                                // A win on the final attempt takes priority over the loss.
                                if (E) begin
                                    estado_q <= GANO;
                                end else if (intentos_inc == MAX_INT4) begin
                                    estado_q <= PERDIO;
                                end
                            end else begin
                                error_q <= 1'b1;
                            end
                        end
                    end
                    // ESPERA, GANO and PERDIO ignore attempts and hold everything.
                    default: begin
                    end
                endcase
            end
        end
    end

    assign igual    = igual_q;
    assign mayor    = mayor_q;
    assign menor    = menor_q;
    assign intentos = intentos_q;
    assign error    = error_q;
    assign jugando  = (estado_q == JUGANDO);
    assign gano     = (estado_q == GANO);
    assign perdio   = (estado_q == PERDIO);

endmodule

// File: tb/tb_control_comparador.sv
// Self-checking bench for control_comparador: directed scenarios followed by random traffic,
// with a queue-based scoreboard fed by the stimulus process and drained by a monitor.
module tb_control_comparador;

    localparam int MAXI = 7;

    logic       clk;
    logic       rst;
    logic       inicio;
    logic       valido;
    logic       E, G, L;
    logic       igual, mayor, menor;
    logic [3:0] intentos;
    logic       jugando, gano, perdio, error;

    control_comparador #(.MAX_INTENTOS(MAXI)) dut (
        .clk      (clk),
        .rst      (rst),
        .inicio   (inicio),
        .valido   (valido),
        .E        (E),
        .G        (G),
        .L        (L),
        .igual    (igual),
        .mayor    (mayor),
        .menor    (menor),
        .intentos (intentos),
        .jugando  (jugando),
        .gano     (gano),
        .perdio   (perdio),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Expected outputs packed as {igual,mayor,menor,intentos[3:0],jugando,gano,perdio,error}
    logic [10:0] expq[$];

    // Reference model: round mode (0 wait, 1 playing, 2 won, 3 lost), attempt count,
    // last accepted code and the strobe level seen at the previous clock.
    int         m_mode = 0;
    int         m_cnt  = 0;
    logic [2:0] m_code = 3'b000;
    logic       m_prev = 1'b0;
    logic       m_err  = 1'b0;

    function automatic logic [10:0] model_outputs();
        return {m_code, 4'(m_cnt), m_mode == 1, m_mode == 2, m_mode == 3, m_err};
    endfunction

    function automatic void model_reset();
        m_mode = 0;
        m_cnt  = 0;
        m_code = 3'b000;
        m_prev = 1'b0;
        m_err  = 1'b0;
    endfunction

    function automatic void model_clock(input logic ini, input logic v, input logic [2:0] egl);
        logic new_attempt;
        new_attempt = v && !m_prev;
        m_prev = v;
        m_err  = 1'b0;
        if (ini) begin
            m_mode = 1;
            m_cnt  = 0;
            m_code = 3'b000;
        end else if (m_mode == 1 && new_attempt) begin
            if ($countones(egl) == 1) begin
                m_cnt  = m_cnt + 1;
                m_code = egl;
                if (egl[2])             m_mode = 2;
                else if (m_cnt == MAXI) m_mode = 3;
            end else begin
                m_err = 1'b1;
            end
        end
    endfunction

    // One clock of stimulus: drive on the falling edge, record what must appear after the rising edge.
    task automatic step(input logic r, input logic ini, input logic v, input logic [2:0] egl);
        @(negedge clk);
        rst    = r;
        inicio = ini;
        valido = v;
        {E, G, L} = egl;
        if (r) model_reset();
        else   model_clock(ini, v, egl);
        expq.push_back(model_outputs());
    endtask

    // Pulse: one cycle high then one cycle low.
    task automatic pulse(input logic [2:0] egl);
        step(1'b0, 1'b0, 1'b1, egl);
        step(1'b0, 1'b0, 1'b0, egl);
    endtask

    // Reset asserted between clock edges; outputs must clear before the next rising edge.
    task automatic async_reset();
        logic [10:0] act;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        act = {igual, mayor, menor, intentos, jugando, gano, perdio, error};
        total++;
        if (act !== 11'd0) begin
            bad++;
            $display("FAIL async_reset: got %b want %b at t=%0t", act, 11'd0, $time);
        end
        model_reset();
        expq.push_back(model_outputs());
    endtask

    // Monitor: after every rising edge, compare DUT outputs with the oldest expectation.
    initial begin
        logic [10:0] exp_v;
        logic [10:0] act_v;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (expq.size() > 0) begin
                exp_v = expq.pop_front();
                act_v = {igual, mayor, menor, intentos, jugando, gano, perdio, error};
                total++;
                if (act_v !== exp_v) begin
                    bad++;
                    $display("FAIL cycle %0d outputs {igual,mayor,menor,intentos,jug,gano,perdio,error}: got %b want %b",
                             cyc, act_v, exp_v);
                end
            end
        end
    end

    localparam logic [2:0] C_E   = 3'b100;
    localparam logic [2:0] C_G   = 3'b010;
    localparam logic [2:0] C_L   = 3'b001;
    localparam logic [2:0] C_EG  = 3'b110;

    initial begin
        logic [2:0] code;
        rst    = 1'b1;
        inicio = 1'b0;
        valido = 1'b0;
        {E, G, L} = 3'b000;

        // Reset state, then idle in ESPERA ignoring attempts.
        step(1'b1, 1'b0, 1'b0, 3'b000);
        step(1'b1, 1'b0, 1'b0, 3'b000);
        step(1'b0, 1'b0, 1'b0, 3'b000);
        pulse(C_G);

        // Win on third attempt.
        step(1'b0, 1'b1, 1'b0, 3'b000);
        pulse(C_G);
        pulse(C_L);
        pulse(C_E);
        pulse(C_G);

        // Loss after MAXI attempts, extra attempt ignored.
        step(1'b0, 1'b1, 1'b0, 3'b000);
        for (int i = 0; i < MAXI; i++) pulse(C_G);
        pulse(C_G);
        pulse(C_EG);

        // Held strobe counts once; illegal code pulses error without counting.
        step(1'b0, 1'b1, 1'b0, 3'b000);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, C_L);
        step(1'b0, 1'b0, 1'b0, C_L);
        pulse(C_EG);
        pulse(3'b000);
        pulse(3'b111);

        // Win on the last attempt, then restart coincident with an attempt edge.
        step(1'b0, 1'b1, 1'b0, 3'b000);
        for (int i = 0; i < MAXI - 1; i++) pulse(C_L);
        pulse(C_E);
        step(1'b0, 1'b1, 1'b1, C_G);
        step(1'b0, 1'b0, 1'b0, C_G);

        // Asynchronous reset mid-round with four attempts, then stay in ESPERA until inicio.
        for (int i = 0; i < 3; i++) pulse(C_G);
        pulse(C_L);
        async_reset();
        step(1'b1, 1'b0, 1'b0, 3'b000);
        pulse(C_G);
        step(1'b0, 1'b1, 1'b0, 3'b000);

        // Strobe already high when reset releases: first cycle is an attempt edge.
        step(1'b0, 1'b0, 1'b0, 3'b000);
        step(1'b1, 1'b1, 1'b1, C_G);
        step(1'b0, 1'b0, 1'b1, C_G);
        step(1'b0, 1'b1, 1'b1, C_G);
        step(1'b0, 1'b0, 1'b1, C_L);
        step(1'b0, 1'b0, 1'b0, C_L);

        // Random traffic.
        step(1'b0, 1'b1, 1'b0, 3'b000);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 2))
                    0:       code = C_E;
                    1:       code = C_G;
                    default: code = C_L;
                endcase
                if ($urandom_range(0, 4) == 0 && code == C_E) code = C_G;
            end else begin
                code = 3'($urandom_range(0, 7));
            end
            step($urandom_range(0, 79) == 0,
                 $urandom_range(0, 24) == 0,
                 1'($urandom_range(0, 1)),
                 code);
        end

        // Drain the scoreboard with a bounded wait.
        repeat (4) @(posedge clk);
        #2;
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
